// File: rtl/pc_sequencer.sv
// Fetch program-counter sequencer: owns the fetch PC, turns execute-stage jump/branch
// decisions into redirects, and raises the flush controls for wrong-path fetches.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jb_valid,
    input  logic [1:0]  jump_sel,
    input  logic [31:0] jb_pc,
    input  logic [15:0] imm16,
    input  logic [25:0] target26,
    input  logic [31:0] rs_val,
    input  logic        stall_in,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        flush_if,
    output logic        flush_id,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        BOOT       = 2'd0,
        RUN        = 2'd1,
        REDIR_PEND = 2'd2
    } state_t;

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;
    localparam logic [1:0] SEL_REG    = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;

    logic [31:0] jb_pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] reg_target;
    logic [31:0] target;
    logic        redirect;
    logic        advance;

    // Branch/jump target candidates; all arithmetic wraps modulo 2^32.
    always_comb begin
        jb_pc_plus4   = jb_pc + 32'd4;
        branch_target = jb_pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
        jump_target   = {jb_pc_plus4[31:28], target26, 2'b00};
        reg_target    = {rs_val[31:2], 2'b00};
    end

    always_comb begin
        target = jb_pc_plus4;
        case (jump_sel)
            SEL_SEQ:    target = jb_pc_plus4;
            SEL_BRANCH: target = branch_target;
            SEL_JUMP:   target = jump_target;
            SEL_REG:    target = reg_target;
            default:    target = jb_pc_plus4;
        endcase
    end

    // A stalled EX re-presents the same jump/branch, so it is only acted on once unstalled.
    always_comb begin
        redirect = (state_q == RUN) && jb_valid && !stall_in && (jump_sel != SEL_SEQ);
        advance  = pc_valid && imem_ready && !stall_in;
    end

    always_comb begin
        pc_valid     = (state_q != BOOT);
        flush_if     = redirect || (state_q == REDIR_PEND);
        flush_id     = redirect && !DELAY_SLOT;
        misalign_err = redirect && (jump_sel == SEL_REG) && (rs_val[1:0] != 2'b00);
        pc           = pc_q;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect) begin
                    if (imem_ready) begin
                        pc_d = target;
                    end else begin
                        pend_d  = target;
                        state_d = REDIR_PEND;
                    end
                end else if (advance) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            REDIR_PEND: begin
                // The fetch returned here is flushed regardless, so a stall cannot hold it off.
                if (imem_ready) begin
                    pc_d    = pend_q;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            pend_q  <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the stimulus queues the expected outputs for each
// cycle and a negedge monitor pops and compares them against two DUT instances.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        jb_valid;
    logic [1:0]  jump_sel;
    logic [31:0] jb_pc;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [31:0] rs_val;
    logic        stall_in;
    logic        imem_ready;

    logic [31:0] pc_a, pc_b;
    logic        pv_a, pv_b, fi_a, fi_b, fid_a, fid_b, me_a, me_b;

    typedef struct packed {
        logic [31:0] pc;
        logic        pv;
        logic        fi;
        logic        fid;   // flush_id expected from the no-delay-slot instance
        logic        me;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   txn = 0;

    pc_sequencer #(.RESET_PC(32'h0000_0000), .DELAY_SLOT(1'b1)) dut_a (
        .clk(clk), .rst(rst), .jb_valid(jb_valid), .jump_sel(jump_sel), .jb_pc(jb_pc),
        .imm16(imm16), .target26(target26), .rs_val(rs_val), .stall_in(stall_in),
        .imem_ready(imem_ready), .pc(pc_a), .pc_valid(pv_a), .flush_if(fi_a),
        .flush_id(fid_a), .misalign_err(me_a)
    );

    pc_sequencer #(.RESET_PC(32'h0000_0000), .DELAY_SLOT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .jb_valid(jb_valid), .jump_sel(jump_sel), .jb_pc(jb_pc),
        .imm16(imm16), .target26(target26), .rs_val(rs_val), .stall_in(stall_in),
        .imem_ready(imem_ready), .pc(pc_b), .pc_valid(pv_b), .flush_if(fi_b),
        .flush_id(fid_b), .misalign_err(me_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            txn++;
            tests_run++;
            if (pc_a !== e.pc || pv_a !== e.pv || fi_a !== e.fi || fid_a !== 1'b0 ||
                me_a !== e.me || pc_b !== e.pc || pv_b !== e.pv || fi_b !== e.fi ||
                fid_b !== e.fid || me_b !== e.me) begin
                tests_failed++;
                $display("FAIL txn%0d: got pc=%h/%h pv=%b/%b fi=%b/%b fid=%b/%b me=%b/%b, want pc=%h pv=%b fi=%b fid=0/%b me=%b",
                         txn, pc_a, pc_b, pv_a, pv_b, fi_a, fi_b, fid_a, fid_b, me_a, me_b,
                         e.pc, e.pv, e.fi, e.fid, e.me);
            end else begin
                $display("[TB] txn%0d ok pc=%h pv=%b fi=%b fid=%b me=%b",
                         txn, pc_a, pv_a, fi_a, fid_b, me_a);
            end
        end
    end

    // Queue one cycle's expectation, then move to just after the next rising edge.
    task automatic step(input logic [31:0] epc, input logic epv, input logic efi,
                        input logic efid, input logic eme);
        exp_t x;
        x.pc  = epc;
        x.pv  = epv;
        x.fi  = efi;
        x.fid = efid;
        x.me  = eme;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic jb(input logic v, input logic [1:0] sel, input logic [31:0] jpc,
                      input logic [15:0] imm, input logic [25:0] tgt, input logic [31:0] rs);
        jb_valid = v;
        jump_sel = sel;
        jb_pc    = jpc;
        imm16    = imm;
        target26 = tgt;
        rs_val   = rs;
    endtask

    initial begin
        rst        = 1'b1;
        stall_in   = 1'b0;
        imem_ready = 1'b1;
        jb(1'b0, 2'b00, 32'h0, 16'h0, 26'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);            // held in reset
        rst = 1'b0;
        step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);            // BOOT
        step(32'h0, 1'b1, 1'b0, 1'b0, 1'b0);            // first fetch of RESET_PC
        step(32'h4, 1'b1, 1'b0, 1'b0, 1'b0);
        jb(1'b1, 2'b01, 32'h100, 16'hFFFC, 26'h0, 32'h0);
        step(32'h8, 1'b1, 1'b1, 1'b1, 1'b0);            // BEQ taken
        jb(1'b1, 2'b10, 32'h3000_0010, 16'h0, 26'h40, 32'h0);
        step(32'hF4, 1'b1, 1'b1, 1'b1, 1'b0);           // J
        jb(1'b1, 2'b11, 32'h0, 16'h0, 26'h0, 32'h1003);
        step(32'h3000_0100, 1'b1, 1'b1, 1'b1, 1'b1);    // JR misaligned
        jb(1'b0, 2'b00, 32'h0, 16'h0, 26'h0, 32'h0);
        step(32'h1000, 1'b1, 1'b0, 1'b0, 1'b0);
        stall_in = 1'b1;
        jb(1'b1, 2'b01, 32'h100, 16'hFFFC, 26'h0, 32'h0);
        step(32'h1004, 1'b1, 1'b0, 1'b0, 1'b0);         // stalled: no redirect
        stall_in = 1'b0;
        step(32'h1004, 1'b1, 1'b1, 1'b1, 1'b0);         // unstalled: redirect taken
        jb(1'b1, 2'b00, 32'h100, 16'hFFFC, 26'h0, 32'h0);
        step(32'hF4, 1'b1, 1'b0, 1'b0, 1'b0);           // not-taken: sequential
        jb(1'b0, 2'b00, 32'h0, 16'h0, 26'h0, 32'h0);
        imem_ready = 1'b0;
        step(32'hF8, 1'b1, 1'b0, 1'b0, 1'b0);           // memory busy: hold
        jb(1'b1, 2'b11, 32'h0, 16'h0, 26'h0, 32'h200);
        step(32'hF8, 1'b1, 1'b1, 1'b1, 1'b0);           // redirect while busy
        jb(1'b1, 2'b10, 32'h0, 16'h0, 26'h123, 32'h0);  // ignored in REDIR_PEND
        step(32'hF8, 1'b1, 1'b1, 1'b0, 1'b0);
        step(32'hF8, 1'b1, 1'b1, 1'b0, 1'b0);
        imem_ready = 1'b1;
        stall_in   = 1'b1;
        step(32'hF8, 1'b1, 1'b1, 1'b0, 1'b0);           // accept cycle, stall ignored
        stall_in = 1'b0;
        jb(1'b0, 2'b00, 32'h0, 16'h0, 26'h0, 32'h0);
        step(32'h200, 1'b1, 1'b0, 1'b0, 1'b0);
        imem_ready = 1'b0;
        jb(1'b1, 2'b11, 32'h0, 16'h0, 26'h0, 32'h200);
        step(32'h204, 1'b1, 1'b1, 1'b1, 1'b0);
        jb(1'b0, 2'b00, 32'h0, 16'h0, 26'h0, 32'h0);
        step(32'h204, 1'b1, 1'b1, 1'b0, 1'b0);          // waiting in REDIR_PEND
        rst        = 1'b1;
        imem_ready = 1'b1;
        step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);            // async reset mid-wait
        step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(32'h0, 1'b1, 1'b0, 1'b0, 1'b0);            // no stale redirect
        step(32'h4, 1'b1, 1'b0, 1'b0, 1'b0);
        jb(1'b1, 2'b11, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFFC);
        step(32'h8, 1'b1, 1'b1, 1'b1, 1'b0);
        jb(1'b0, 2'b00, 32'h0, 16'h0, 26'h0, 32'h0);
        step(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b0);
        step(32'h0, 1'b1, 1'b0, 1'b0, 1'b0);            // wrap to zero
        @(negedge clk);
        #1;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the five-stage MIPS core. It owns the fetch PC register and turns the execute-stage jump/branch decision (the 2-bit jump-select code) into a next-PC value. It issues fetch requests to instruction memory and generates the flush controls that squash wrong-path instructions. It sits between the execute stage, the hazard unit and the instruction-memory port.

## Interface
- RESET_PC, 32'h0000_0000, fetch address presented after reset.
- DELAY_SLOT, 1, 1: architectural branch delay slot (only IF squashed on redirect); 0: IF and ID both squashed.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- jb_valid  input  1  execute-stage instruction is a resolved jump/branch this cycle.
- jump_sel  input  2  00 PC+4 (not taken), 01 PC+4+SEXT(imm), 10 {PC+4[31:28],target,2'b0}, 11 RS.
- jb_pc  input  32  PC of the jump/branch instruction.
- imm16  input  16  branch immediate, word offset.
- target26  input  26  J/JAL target field.
- rs_val  input  32  forwarded RS value for JR/JALR.
- stall_in  input  1  hazard-unit pipeline stall.
- imem_ready  input  1  instruction memory accepts/returns fetch at pc this cycle.
- pc  output  32  current fetch address.
- pc_valid  output  1  fetch request valid.
- flush_if  output  1  instruction returned this cycle must enter IF/ID as a bubble.
- flush_id  output  1  instruction in ID must be squashed (DELAY_SLOT=0 only).
- misalign_err  output  1  JR/JALR target had rs_val[1:0] != 0.

## Operation
- States: BOOT, RUN, REDIR_PEND.
- BOOT: entered on reset. pc_valid=0. Next cycle goes to RUN unconditionally.
- advance = pc_valid & imem_ready & !stall_in.
- redirect = (state==RUN) & jb_valid & !stall_in & (jump_sel != 00). jb_valid is ignored while stalled, because EX re-presents the instruction.
- Target computation uses 32-bit modulo arithmetic:
  - 01: jb_pc + 4 + {{14{imm16[15]}}, imm16, 2'b00}.
  - 10: {jb_pc_plus4[31:28], target26, 2'b00}.
  - 11: {rs_val[31:2], 2'b00}. misalign_err = redirect & (jump_sel==11) & (rs_val[1:0]!=0). The target is force-aligned, never trapped here.
- RUN behaviour:
  - redirect & imem_ready: pc <= target; flush_if=1. The instruction fetched this cycle is wrong-path; the delay slot is already in ID.
  - redirect & !imem_ready: target latched into a pending register; pc held; flush_if=1; go to REDIR_PEND.
  - otherwise, on advance: pc <= pc + 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
  - otherwise: pc held.
- REDIR_PEND behaviour:
  - pc still shows the old (wrong-path) address; pc_valid=1; flush_if=1 every cycle; jb_valid ignored.
  - On imem_ready: pc <= pending target; go to RUN. stall_in does not block this load, because the returned instruction is flushed anyway.
- flush_id = redirect & (DELAY_SLOT==0).
- flush_if, flush_id and misalign_err are combinational from state and inputs; they are 0 in BOOT.

## Timing
- Reset values: pc=RESET_PC, pc_valid=0, flush_if=0, flush_id=0, misalign_err=0, state=BOOT, pending register cleared.
- Reset is asynchronous: assertion at any time, including mid REDIR_PEND, immediately restores reset values and discards the pending target.
- pc_valid rises on the first rising edge after rst deasserts. The first fetch of RESET_PC occurs in that cycle.
- Redirect latency: target appears on pc one cycle after the redirect cycle when imem_ready=1. Otherwise it appears one cycle after the first imem_ready in REDIR_PEND.
- Sequential fetch throughput: one pc+4 per cycle while advance holds.
- Simultaneous stall_in and jb_valid: no redirect, pc held, no flush.
- Simultaneous redirect and advance: redirect wins; pc+4 is discarded.

## Test plan
- Release reset with imem_ready=1, no jb_valid -> pc 0x0, 0x4, 0x8 on successive cycles; pc_valid=1 from the first post-reset cycle; all flushes 0.
- BEQ taken: jb_valid=1, jump_sel=01, jb_pc=0x100, imm16=16'hFFFC -> next pc=0x0F4; flush_if=1 for one cycle; flush_id=0 (DELAY_SLOT=1), flush_id=1 when DELAY_SLOT=0.
- J: jump_sel=10, jb_pc=0x3000_0010, target26=26'h40 -> next pc=0x3000_0100.
- JR: jump_sel=11, rs_val=0x1003 -> next pc=0x1000; misalign_err=1 for exactly that cycle.
- Redirect to 0x200 with imem_ready=0 for 3 cycles:
  - pc holds the old value; flush_if=1 in all 4 cycles, including the accept cycle.
  - pc=0x200 on the cycle after imem_ready rises.
  - Assert rst during the wait in a repeat run -> pc=RESET_PC immediately; after release, no redirect to 0x200 occurs.
- stall_in=1 with jb_valid=1, jump_sel=01 -> pc held, flush_if=0; deassert stall_in with jb_valid still 1 -> redirect taken on that cycle.
